// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   state_t        - receiver FSM encoding (IDLE/START/DATA/STOP)
//   DEF_DATA_BITS  - default data bits per frame
//   DEF_OVERSAMPLE - default sample ticks per bit period
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the receiver's line-side and result-side signals.
//   sample_tick - one-clk enable from the baud counter (oversample tick)
//   rx          - asynchronous serial line, idles high
//   rx_data     - last good word, held until the next good frame
//   rx_valid    - one-clk strobe, rx_data is new
//   frame_err   - one-clk strobe, stop bit sampled low
//   busy        - receiver is inside a frame
//   dbg_state   - current FSM state, for checkers
//
// Handshake: there is no ready/backpressure. rx_valid and frame_err are
// single-cycle, mutually exclusive strobes; a consumer must capture rx_data
// in the cycle rx_valid is high (it stays valid until the next good frame).
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);
  import uart_pkg::*;

  logic                 sample_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
  state_t               dbg_state;

  // master: the environment driving the line and consuming results
  modport master (
    output sample_tick, rx,
    input  rx_data, rx_valid, frame_err, busy, dbg_state
  );

  // slave: the receiver itself
  modport slave (
    input  sample_tick, rx,
    output rx_data, rx_valid, frame_err, busy, dbg_state
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk     - destination clock
//   rst     - asynchronous active-low reset, loads RST_VAL into both flops
//   d       - asynchronous input
//   q       - synchronized output (2 clk latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, DATA_BITS data bits LSB first plus
// one stop bit, no parity. Bit timing advances only on sample_tick.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - uart_rx_if slave port (sample_tick, rx in; rx_data, rx_valid,
//          frame_err, busy, dbg_state out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // Line conditioning: rx_s is the synchronized line, rx_d its previous value.
  logic rx_s;
  logic rx_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_d <= 1'b1;
    else      rx_d <= rx_s;
  end

  // FSM state and datapath registers
  state_t                state, state_nxt;
  logic [TW-1:0]         tick_cnt, tick_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]  shift_reg, shift_nxt;
  logic [DATA_BITS-1:0]  data_q, data_nxt;
  logic                  valid_q, valid_nxt;
  logic                  ferr_q, ferr_nxt;

  // Process 1: state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      ferr_q    <= ferr_nxt;
    end
  end

  // Process 2: next-state and next-datapath logic.
  // The strobes are computed here and registered, so they appear in the
  // cycle after the edge that consumes the stop-bit tick, together with the
  // return to IDLE.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        // Edge detection runs every clk; a line that is already low (break)
        // never looks like a start bit.
        if (rx_d && !rx_s) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end

      START: begin
        if (bus.sample_tick) begin
          if (tick_cnt == HALF_M1) begin
            // Half a bit after the edge: confirm the start bit is still low,
            // which also aligns later samples to bit centers.
            tick_nxt = '0;
            bit_nxt  = '0;
            if (!rx_s) state_nxt = DATA;
            else       state_nxt = IDLE;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (bus.sample_tick) begin
          if (tick_cnt == FULL_M1) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + BW'(1);
            tick_nxt  = '0;
            if (bit_cnt == LAST_BIT) state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      STOP: begin
        if (bus.sample_tick) begin
          if (tick_cnt == FULL_M1) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            if (rx_s) begin
              data_nxt  = shift_reg;
              valid_nxt = 1'b1;
            end else begin
              ferr_nxt  = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Process 3: outputs, all derived from registers
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.dbg_state = state;
    bus.rx_data   = data_q;
    bus.rx_valid  = valid_q;
    bus.frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx. Frames are built
// bit by bit from a byte and a stop value; the model predicts one result per
// frame (good byte, or frame error with the previous good byte held).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int W  = DB + 1;   // {frame_err, rx_data}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;

  logic [W-1:0]  exp_q[$];
  logic [DB-1:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- sample_tick generator ----------------
  int tick_div = 1;
  bit tick_en  = 1'b1;

  initial begin
    int tcnt;
    tcnt = 0;
    bus.sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && tcnt >= tick_div - 1) begin
        bus.sample_tick = 1'b1;
        tcnt = 0;
      end else begin
        bus.sample_tick = 1'b0;
        if (tick_en) tcnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.sample_tick) k++;
    end
    #1;
  endtask

  // Drive one frame; the model records what the receiver must report.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, d});
      last_data = d;
    end else begin
      exp_q.push_back({1'b1, last_data});
    end
    bus.rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      bus.rx = d[i];
      wait_ticks(OS);
    end
    bus.rx = stop;
    wait_ticks(OS);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_state"}, bus.dbg_state, IDLE);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    last_data = '0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_strobe = 1'b0;
      end else begin
        if (prev_strobe)
          check("strobe_one_cycle", {bus.rx_valid, bus.frame_err}, 2'b00);
        if (bus.rx_valid || bus.frame_err) begin
          if (bus.rx_valid) n_valid++;
          if (bus.frame_err) n_ferr++;
          check("strobe_exclusive", bus.rx_valid & bus.frame_err, 1'b0);
          if (exp_q.size() == 0) begin
            check("spurious_strobe", {bus.rx_valid, bus.frame_err}, 2'b00);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("frame_result", {bus.frame_err, bus.rx_data}, e);
          end
          check("busy_at_strobe", bus.busy, 1'b0);
        end
        prev_strobe = bus.rx_valid | bus.frame_err;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int v0, f0;
    last_data = '0;
    bus.rx = 1'b1;
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_rx_data", bus.rx_data, '0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", bus.dbg_state, IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 0x55, tick every clk
    tick_div = 1;
    v0 = n_valid;
    send_frame(8'h55, 1'b1);
    wait_ticks(OS);
    drain("f55");
    check("f55_nvalid", n_valid - v0, 1);
    check("f55_data", bus.rx_data, 8'h55);

    // Back-to-back 0xA3, 0x0F, tick every 10 clk
    tick_div = 10;
    v0 = n_valid;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    drain("b2b");
    check("b2b_nvalid", n_valid - v0, 2);

    // False start: low for 4 ticks
    tick_div = 2;
    v0 = n_valid; f0 = n_ferr;
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    @(negedge clk);
    check("false_start_state", bus.dbg_state, IDLE);
    check("false_start_busy", bus.busy, 1'b0);
    check("false_start_strobes", (n_valid - v0) + (n_ferr - f0), 0);
    send_frame(8'h3C, 1'b1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    drain("f3c");
    check("f3c_data", bus.rx_data, 8'h3C);

    // 0x81 with bad stop, then break for 40 bit periods
    tick_div = 1;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b0);
    wait_ticks(40 * OS);
    @(negedge clk);
    check("break_nferr", n_ferr - f0, 1);
    check("break_nvalid", n_valid - v0, 0);
    check("break_state", bus.dbg_state, IDLE);
    check("break_data_held", bus.rx_data, 8'h3C);
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h5A, 1'b1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    drain("after_break");
    check("after_break_nvalid", n_valid - v0, 1);

    // Reset during data bit 3
    tick_div = 1;
    bus.rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      bus.rx = i[0];
      wait_ticks(OS);
    end
    bus.rx = 1'b1;
    wait_ticks(OS / 2);
    check("pre_rst_busy", bus.busy, 1'b1);
    check("pre_rst_state", bus.dbg_state, DATA);
    rst = 1'b0;
    #1;
    check("midrst_rx_data", bus.rx_data, '0);
    check("midrst_rx_valid", bus.rx_valid, 1'b0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_state", bus.dbg_state, IDLE);
    do_reset();
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hC3, 1'b1);
    bus.rx = 1'b1;
    wait_ticks(OS);
    drain("fc3");
    check("fc3_strobes", (n_valid - v0) * 16 + (n_ferr - f0), 16);
    check("fc3_data", bus.rx_data, 8'hC3);

    // sample_tick stalled mid-frame for 500 clk
    tick_div = 2;
    v0 = n_valid;
    fork
      send_frame(8'h96, 1'b1);
      begin
        wait_ticks(60);
        tick_en = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("stall_state", bus.dbg_state, DATA);
        check("stall_busy", bus.busy, 1'b1);
        check("stall_no_strobe", n_valid - v0, 0);
        tick_en = 1'b1;
      end
    join
    bus.rx = 1'b1;
    wait_ticks(OS);
    drain("f96");
    check("f96_data", bus.rx_data, 8'h96);

    // Randomized frames: random data, stop bit, tick rate and idle gap
    for (int n = 0; n < 14; n++) begin
      logic [DB-1:0] d;
      logic          stp;
      d = DB'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      tick_div = $urandom_range(1, 4);
      send_frame(d, stp);
      bus.rx = 1'b1;
      if (!stp)
        wait_ticks(OS);
      else
        wait_ticks($urandom_range(0, 2) * OS + $urandom_range(0, OS / 2));
    end
    wait_ticks(OS);
    drain("random");
    check("random_last_data", bus.rx_data, last_data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
